// File: rtl/fifo_frame_pkg.sv
// Shared definitions for the write-side packet framer: control word types,
// framer FSM states and the control word builder.
package fifo_frame_pkg;

  localparam logic [1:0] HDR     = 2'b00;
  localparam logic [1:0] TRL     = 2'b01;
  localparam logic [1:0] TRL_ERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PAY   = 2'd1,
    ST_TRL   = 2'd2,
    ST_DRAIN = 2'd3
  } fsm_state_e;

  // Builds {1, typ, value} right-aligned; vw is the value field width (DATA_SIZE-3).
  function automatic logic [31:0] mk_ctrl(input logic [1:0] typ, input logic [31:0] value,
                                          input int vw = 9);
    logic [31:0] mask;
    mask = (32'd1 << vw) - 32'd1;
    return (32'd1 << (vw + 2)) | ({30'd0, typ} << vw) | (value & mask);
  endfunction

endpackage

// File: rtl/fifo_wr_stage.sv
// Output register stage for the FIFO write port; holds winc/wData while the
// FIFO reports full and accepts a new word only when free.
module fifo_wr_stage #(
  parameter int DATA_SIZE = 12
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 load,
  input  logic [DATA_SIZE-1:0] word,
  input  logic                 wFull,
  output logic                 winc,
  output logic [DATA_SIZE-1:0] wData,
  output logic                 free
);

  logic                 winc_q, winc_d;
  logic [DATA_SIZE-1:0] data_q, data_d;

  assign free  = ~winc_q | ~wFull;
  assign winc  = winc_q;
  assign wData = data_q;

  always_comb begin
    winc_d = winc_q;
    data_d = data_q;
    if (free) begin
      winc_d = load;
      if (load) data_d = word;
    end
  end

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      winc_q <= 1'b0;
      data_q <= '0;
    end else begin
      winc_q <= winc_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/fifo_write_framer.sv
// Write-side packet framer: wraps upstream packets in header/trailer control
// words and feeds them to the async FIFO write port.
module fifo_write_framer
  import fifo_frame_pkg::*;
#(
  parameter int DATA_SIZE = 12,
  parameter int MAX_LEN   = 256
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_SIZE-2:0] s_data,
  input  logic                 s_last,
  input  logic                 wFull,
  output logic                 winc,
  output logic [DATA_SIZE-1:0] wData,
  output logic                 busy,
  output logic                 trunc_pulse
);

  localparam int VW = DATA_SIZE - 3;

  fsm_state_e           state_q, state_d;
  logic [VW-1:0]        seq_q, seq_d;
  logic [VW-1:0]        count_q, count_d;
  logic                 err_q, err_d;
  logic                 trunc_q, trunc_d;
  logic                 free;
  logic                 load;
  logic [DATA_SIZE-1:0] word;

  fifo_wr_stage #(.DATA_SIZE(DATA_SIZE)) u_stage (
    .wclk  (wclk),
    .wrst  (wrst),
    .load  (load),
    .word  (word),
    .wFull (wFull),
    .winc  (winc),
    .wData (wData),
    .free  (free)
  );

  assign busy        = (state_q != ST_IDLE) || winc;
  assign trunc_pulse = trunc_q;

  // s_ready depends only on state and the stage, never on s_valid.
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    count_d = count_q;
    err_d   = err_q;
    trunc_d = 1'b0;
    load    = 1'b0;
    word    = '0;
    s_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_valid && free) begin
          load    = 1'b1;
          word    = DATA_SIZE'(mk_ctrl(HDR, 32'(seq_q), VW));
          state_d = ST_PAY;
        end
      end
      ST_PAY: begin
        s_ready = free;
        if (s_valid && free) begin
          load    = 1'b1;
          word    = {1'b0, s_data};
          count_d = count_q + 1'b1;
          if (s_last) begin
            state_d = ST_TRL;
            err_d   = 1'b0;
          end else if (count_d == VW'(MAX_LEN)) begin
            state_d = ST_TRL;
            err_d   = 1'b1;
          end
        end
      end
      ST_TRL: begin
        if (free) begin
          load    = 1'b1;
          word    = DATA_SIZE'(mk_ctrl(err_q ? TRL_ERR : TRL, 32'(count_q), VW));
          trunc_d = err_q;
          count_d = '0;
          seq_d   = seq_q + 1'b1;
          state_d = err_q ? ST_DRAIN : ST_IDLE;
          err_d   = 1'b0;
        end
      end
      ST_DRAIN: begin
        // Rest of an over-long packet is swallowed up to its s_last.
        s_ready = 1'b1;
        if (s_valid && s_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      state_q <= ST_IDLE;
      seq_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      count_q <= count_d;
      err_q   <= err_d;
      trunc_q <= trunc_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_framer.sv
// Self-checking bench for fifo_write_framer: packet-level expected-word model,
// per-cycle scoreboard on consumed FIFO words, plus literal pins.
module tb_fifo_write_framer;

  localparam int DS = 12;
  localparam int ML = 4;

  logic          wclk = 1'b0;
  logic          wrst = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          wFull = 1'b0;
  logic [DS-2:0] s_data = '0;
  logic          s_ready, winc, busy, trunc_pulse;
  logic [DS-1:0] wData;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int seq_m = 0;
  int trunc_cnt = 0;
  logic [DS-1:0] last_hdr = '0;
  logic [DS-1:0] exp_q[$];
  logic [DS-1:0] got_q[$];
  int            got_cyc[$];
  logic [DS-1:0] lit1[5];

  fifo_write_framer #(.DATA_SIZE(DS), .MAX_LEN(ML)) dut (
    .wclk        (wclk),
    .wrst        (wrst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .wFull       (wFull),
    .winc        (winc),
    .wData       (wData),
    .busy        (busy),
    .trunc_pulse (trunc_pulse)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, want);
    end else begin
      $display("[TB] ok %s = 0x%0h", name, act);
    end
  endtask

  // Expected FIFO words for one packet of len words starting at payload base.
  task automatic model_pkt(input int len, input logic [DS-2:0] base);
    int n;
    n = (len > ML) ? ML : len;
    exp_q.push_back({3'b100, 9'(seq_m)});
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, base + 11'(i)});
    exp_q.push_back({1'b1, (len > ML) ? 2'b11 : 2'b01, 9'(n)});
    seq_m = (seq_m + 1) % 512;
  endtask

  task automatic send_word(input logic [DS-2:0] d, input logic l);
    bit acc;
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    n = 0;
    acc = 1'b0;
    do begin
      #1;
      acc = s_ready;
      @(negedge wclk);
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got no accept, required accept of 0x%0h", d);
    end
  endtask

  task automatic send_pkt(input int len, input logic [DS-2:0] base, input bit drop);
    model_pkt(len, base);
    for (int i = 0; i < len; i++) send_word(base + 11'(i), (i == len - 1));
    if (drop) begin
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge wclk);
      n++;
    end
    repeat (2) @(negedge wclk);
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Per-cycle compare process, sampled between edges.
  initial begin
    logic          stall_prev;
    logic          trunc_prev;
    logic [DS-1:0] data_prev;
    stall_prev = 1'b0;
    trunc_prev = 1'b0;
    data_prev  = '0;
    forever begin
      @(negedge wclk);
      #2;
      cyc++;
      if (!wrst) begin
        stall_prev = 1'b0;
        trunc_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("hold_winc", 32'(winc), 32'd1);
          chk("hold_wdata", 32'(wData), 32'(data_prev));
        end
        if (winc) chk("busy_with_winc", 32'(busy), 32'd1);
        if (trunc_pulse) begin
          trunc_cnt++;
          chk("trunc_word", 32'({winc, wData[DS-1 -: 3]}), 32'hF);
          chk("trunc_single", 32'(trunc_prev), 32'd0);
        end
        if (winc && !wFull) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_word: got 0x%0h, required no write", wData);
          end else begin
            chk("word", 32'(wData), 32'(exp_q.pop_front()));
          end
          got_q.push_back(wData);
          got_cyc.push_back(cyc);
          if (wData[DS-1 -: 3] == 3'b100) last_hdr = wData;
        end
        stall_prev = winc && wFull;
        data_prev  = wData;
        trunc_prev = trunc_pulse;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    lit1[0] = 12'h800; lit1[1] = 12'h001; lit1[2] = 12'h002;
    lit1[3] = 12'h003; lit1[4] = 12'hA03;

    // Reset state
    repeat (3) @(negedge wclk);
    #1;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_winc", 32'(winc), 32'd0);
    chk("rst_wdata", 32'(wData), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_trunc", 32'(trunc_pulse), 32'd0);
    @(negedge wclk);
    wrst = 1'b1;
    @(negedge wclk);

    // 3-word packet, then next header
    got_q.delete();
    send_pkt(3, 11'h001, 1'b1);
    wait_drain("drain_3word");
    chk("pkt3_len", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk("pkt3_word", 32'(got_q[i]), 32'(lit1[i]));
    chk("idle_busy", 32'(busy), 32'd0);
    send_pkt(1, 11'h055, 1'b1);
    wait_drain("drain_next");
    chk("next_hdr", 32'(last_hdr), 32'h801);

    // Over-long packet truncated at MAX_LEN
    got_q.delete();
    send_pkt(6, 11'h010, 1'b1);
    wait_drain("drain_trunc");
    chk("trunc_len", 32'(got_q.size()), 32'd6);
    chk("trunc_hdr", 32'(got_q[0]), 32'h802);
    chk("trunc_trl", 32'(got_q[5]), 32'hE04);
    chk("trunc_cnt", 32'(trunc_cnt), 32'd1);
    send_pkt(1, 11'h066, 1'b1);
    wait_drain("drain_after_trunc");
    chk("hdr_after_trunc", 32'(last_hdr), 32'h803);

    // Exactly MAX_LEN words with s_last: normal trailer
    got_q.delete();
    send_pkt(4, 11'h030, 1'b1);
    wait_drain("drain_exact");
    chk("exact_trl", 32'(got_q[got_q.size()-1]), 32'hA04);
    chk("exact_no_trunc", 32'(trunc_cnt), 32'd1);

    // wFull held for 5 cycles mid-payload
    got_q.delete();
    fork
      send_pkt(4, 11'h040, 1'b1);
      begin
        repeat (3) @(negedge wclk);
        wFull = 1'b1;
        repeat (5) begin
          #1;
          chk("full_s_ready", 32'(s_ready), 32'd0);
          chk("full_winc", 32'(winc), 32'd1);
          @(negedge wclk);
        end
        wFull = 1'b0;
      end
    join
    wait_drain("drain_full");
    chk("full_len", 32'(got_q.size()), 32'd6);
    chk("full_trl", 32'(got_q[5]), 32'hA04);

    // Reset after header and two payload accepts
    exp_q.push_back({3'b100, 9'(seq_m)});
    exp_q.push_back({1'b0, 11'h020});
    s_valid = 1'b1;
    s_data  = 11'h020;
    s_last  = 1'b0;
    repeat (3) @(negedge wclk);
    #1 wrst = 1'b0;
    #2;
    chk("arst_winc", 32'(winc), 32'd0);
    chk("arst_wdata", 32'(wData), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_s_ready", 32'(s_ready), 32'd0);
    chk("arst_partial_written", 32'(exp_q.size()), 32'd0);
    s_valid = 1'b0;
    exp_q.delete();
    seq_m = 0;
    @(negedge wclk);
    wrst = 1'b1;
    @(negedge wclk);
    send_pkt(1, 11'h077, 1'b1);
    wait_drain("drain_post_rst");
    chk("post_rst_hdr", 32'(last_hdr), 32'h800);

    // Back-to-back packets with s_valid held high
    got_q.delete();
    got_cyc.delete();
    send_pkt(2, 11'h100, 1'b0);
    send_pkt(1, 11'h110, 1'b0);
    send_pkt(3, 11'h120, 1'b1);
    wait_drain("drain_b2b");
    chk("b2b_len", 32'(got_q.size()), 32'd12);
    for (int i = 0; i + 1 < got_q.size(); i++)
      if (got_q[i][DS-1 -: 3] == 3'b101)
        chk("b2b_trl_to_hdr", 32'(got_cyc[i+1] - got_cyc[i]), 32'd1);

    // 512 single-word packets: sequence wrap
    got_q.delete();
    for (int i = 0; i < 512; i++) send_pkt(1, 11'(i), (i == 511));
    wait_drain("drain_wrap");
    chk("wrap_len", 32'(got_q.size()), 32'd1536);
    chk("wrap_first_hdr", 32'(got_q[0]), 32'h804);
    chk("wrap_first_trl", 32'(got_q[2]), 32'hA01);
    chk("wrap_hdr", 32'(got_q[3*508]), 32'h800);
    chk("wrap_last_trl", 32'(got_q[1535]), 32'hA01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
